// File: rtl/buyruk_onbellegi_kume.sv
// buyruk_onbellegi_kume: N-way set-associative instruction cache.
//
// Sits between the fetch stage and the main-memory line interface.
// - Hits return one 32-bit instruction per cycle. Back-to-back requests are accepted while a hit is presented.
// - A miss raises a line-refill request. The returned line is written into the way chosen by a per-set
//   round-robin pointer, and the requested word is then forwarded.
//
// Optional feature: define BUYRUK_ONBELLEGI_SAYAC_EN to add the hit and miss counters
// (isabet_sayisi_o / iskalama_sayisi_o).
//
// Ports:
//   clk_i             clock
//   rst_i             asynchronous active-low reset
//   istek_i           fetch request valid
//   adres_i           fetch byte address (bits [1:0] ignored)
//   istek_hazir_o     request accepted when istek_i && istek_hazir_o
//   durdur_i          pipeline stall
//   temizle_i         invalidate all lines (single-cycle pulse)
//   buyruk_o          instruction
//   buyruk_gecerli_o  buyruk_o valid
//   obek_istek_o      line refill request, held until served
//   obek_adres_o      line-aligned refill address
//   obek_gecerli_i    refill data valid (one-cycle pulse)
//   obek_i            refill line, byte 0 at bits [7:0]
//   isabet_sayisi_o   consumed hits   (BUYRUK_ONBELLEGI_SAYAC_EN only)
//   iskalama_sayisi_o misses          (BUYRUK_ONBELLEGI_SAYAC_EN only)
module buyruk_onbellegi_kume #(
  parameter int YOL_SAYISI  = 2,
  parameter int KUME_SAYISI = 64,
  parameter int OBEK_BIT    = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                istek_i,
  input  logic [31:0]         adres_i,
  output logic                istek_hazir_o,
  input  logic                durdur_i,
  input  logic                temizle_i,
  output logic [31:0]         buyruk_o,
  output logic                buyruk_gecerli_o,
  output logic                obek_istek_o,
  output logic [31:0]         obek_adres_o,
  input  logic                obek_gecerli_i,
  input  logic [OBEK_BIT-1:0] obek_i
`ifdef BUYRUK_ONBELLEGI_SAYAC_EN
  ,
  output logic [31:0]         isabet_sayisi_o,
  output logic [31:0]         iskalama_sayisi_o
`endif
);

  localparam int OFS    = $clog2(OBEK_BIT / 8);
  localparam int IDX    = $clog2(KUME_SAYISI);
  localparam int ETIKET = 32 - IDX - OFS;
  localparam int PTR_W  = (YOL_SAYISI > 1) ? $clog2(YOL_SAYISI) : 1;

  typedef enum logic [1:0] {BOSTA, ARA, ANABELLEK, YANIT} durum_t;

  durum_t                 durum_reg;
  logic [31:2]            adres_reg;
  logic [31:0]            yanit_kelime_reg;
  logic                   temizle_bekle_reg;
  logic [YOL_SAYISI-1:0]  gecerli_reg [KUME_SAYISI];
  logic [PTR_W-1:0]       ptr_reg     [KUME_SAYISI];
  logic [ETIKET-1:0]      etiket_reg  [KUME_SAYISI][YOL_SAYISI];
  logic [OBEK_BIT-1:0]    satir_reg   [KUME_SAYISI][YOL_SAYISI];

  logic [IDX-1:0]         ara_kume;
  logic [ETIKET-1:0]      ara_etiket;
  logic [OFS-3:0]         ara_kelime;
  logic [YOL_SAYISI-1:0]  yol_isabet;
  logic                   isabet;
  logic [OBEK_BIT-1:0]    isabet_satir;
  logic [31:0]            isabet_kelime;
  logic [31:0]            dolum_kelime;
  logic                   dolum;
  logic                   temizle_simdi;
  logic                   unused_bitler;

  // Byte-within-word bits never matter for word-aligned fetches.
  assign unused_bitler = ^adres_i[1:0];

  assign ara_kume   = adres_reg[IDX+OFS-1:OFS];
  assign ara_etiket = adres_reg[31:IDX+OFS];
  assign ara_kelime = adres_reg[OFS-1:2];

  for (genvar gi = 0; gi < YOL_SAYISI; gi++) begin : g_yol
    assign yol_isabet[gi] = gecerli_reg[ara_kume][gi] &&
                            (etiket_reg[ara_kume][gi] == ara_etiket);
  end

  always_comb begin
    isabet       = 1'b0;
    isabet_satir = '0;
    for (int w = 0; w < YOL_SAYISI; w++) begin
      if (yol_isabet[w]) begin
        isabet       = 1'b1;
        isabet_satir = satir_reg[ara_kume][w];
      end
    end
  end

  assign isabet_kelime = isabet_satir[{ara_kelime, 5'b0} +: 32];
  assign dolum_kelime  = obek_i[{ara_kelime, 5'b0} +: 32];
  assign dolum         = (durum_reg == ANABELLEK) && obek_gecerli_i;

  // A flush seen while a refill is in flight is deferred until the response
  // has been consumed, so the fresh line is invalidated as well.
  assign temizle_simdi = (temizle_i && (durum_reg != ANABELLEK)) ||
                         ((durum_reg == YANIT) && !durdur_i && temizle_bekle_reg);

  always_comb begin
    istek_hazir_o    = 1'b0;
    buyruk_gecerli_o = 1'b0;
    buyruk_o         = '0;
    obek_istek_o     = 1'b0;
    obek_adres_o     = '0;
    case (durum_reg)
      BOSTA: istek_hazir_o = !durdur_i;
      ARA: begin
        istek_hazir_o    = isabet && !durdur_i;
        buyruk_gecerli_o = isabet;
        buyruk_o         = isabet ? isabet_kelime : 32'd0;
      end
      ANABELLEK: begin
        obek_istek_o = 1'b1;
        obek_adres_o = {adres_reg[31:OFS], {OFS{1'b0}}};
      end
      YANIT: begin
        istek_hazir_o    = !durdur_i;
        buyruk_gecerli_o = 1'b1;
        buyruk_o         = yanit_kelime_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_reg         <= BOSTA;
      adres_reg         <= '0;
      yanit_kelime_reg  <= '0;
      temizle_bekle_reg <= 1'b0;
      for (int k = 0; k < KUME_SAYISI; k++) begin
        gecerli_reg[k] <= '0;
        ptr_reg[k]     <= '0;
      end
    end else begin
      if (temizle_simdi) begin
        for (int k = 0; k < KUME_SAYISI; k++) gecerli_reg[k] <= '0;
      end
      if (dolum) begin
        gecerli_reg[ara_kume][ptr_reg[ara_kume]] <= 1'b1;
        ptr_reg[ara_kume] <= (ptr_reg[ara_kume] == PTR_W'(YOL_SAYISI - 1))
                             ? '0 : ptr_reg[ara_kume] + 1'b1;
      end
      case (durum_reg)
        BOSTA: begin
          if (istek_i && !durdur_i) begin
            adres_reg <= adres_i[31:2];
            durum_reg <= ARA;
          end
        end
        ARA: begin
          if (!isabet) begin
            durum_reg <= ANABELLEK;
          end else if (!durdur_i) begin
            if (istek_i) adres_reg <= adres_i[31:2];
            else         durum_reg <= BOSTA;
          end
        end
        ANABELLEK: begin
          if (temizle_i) temizle_bekle_reg <= 1'b1;
          if (obek_gecerli_i) begin
            yanit_kelime_reg <= dolum_kelime;
            durum_reg        <= YANIT;
          end
        end
        YANIT: begin
          if (!durdur_i) begin
            temizle_bekle_reg <= 1'b0;
            if (istek_i) begin
              adres_reg <= adres_i[31:2];
              durum_reg <= ARA;
            end else begin
              durum_reg <= BOSTA;
            end
          end
        end
        default: durum_reg <= BOSTA;
      endcase
    end
  end

  // Tag and line storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (dolum) begin
      etiket_reg[ara_kume][ptr_reg[ara_kume]] <= ara_etiket;
      satir_reg[ara_kume][ptr_reg[ara_kume]]  <= obek_i;
    end
  end

`ifdef BUYRUK_ONBELLEGI_SAYAC_EN
  // A hit counts once, in the cycle its output is actually taken (no stall);
  // a miss counts on the ARA->ANABELLEK transition.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      isabet_sayisi_o   <= '0;
      iskalama_sayisi_o <= '0;
    end else if (durum_reg == ARA) begin
      if (isabet && !durdur_i) isabet_sayisi_o   <= isabet_sayisi_o + 32'd1;
      if (!isabet)             iskalama_sayisi_o <= iskalama_sayisi_o + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_buyruk_onbellegi_kume.sv
// tb_buyruk_onbellegi_kume: directed self-checking bench for the
// set-associative instruction cache (default parameters, OFS=4, IDX=6).
module tb_buyruk_onbellegi_kume;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         istek_i;
  logic [31:0]  adres_i;
  logic         istek_hazir_o;
  logic         durdur_i;
  logic         temizle_i;
  logic [31:0]  buyruk_o;
  logic         buyruk_gecerli_o;
  logic         obek_istek_o;
  logic [31:0]  obek_adres_o;
  logic         obek_gecerli_i;
  logic [127:0] obek_i;
`ifdef BUYRUK_ONBELLEGI_SAYAC_EN
  logic [31:0]  isabet_sayisi_o;
  logic [31:0]  iskalama_sayisi_o;
`endif

  int gecen  = 0;
  int toplam = 0;

  localparam logic [127:0] SATIR_T1 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] SATIR_A  = 128'h10000003_10000002_10000001_10000000;
  localparam logic [127:0] SATIR_B  = 128'h20000003_20000002_20000001_20000000;
  localparam logic [127:0] SATIR_C  = 128'h30000003_30000002_30000001_30000000;
  localparam logic [127:0] SATIR_D  = 128'h50000003_50000002_50000001_50000000;
  localparam logic [127:0] SATIR_E  = 128'h60000003_60000002_60000001_60000000;

  buyruk_onbellegi_kume dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .istek_i          (istek_i),
    .adres_i          (adres_i),
    .istek_hazir_o    (istek_hazir_o),
    .durdur_i         (durdur_i),
    .temizle_i        (temizle_i),
    .buyruk_o         (buyruk_o),
    .buyruk_gecerli_o (buyruk_gecerli_o),
    .obek_istek_o     (obek_istek_o),
    .obek_adres_o     (obek_adres_o),
    .obek_gecerli_i   (obek_gecerli_i),
    .obek_i           (obek_i)
`ifdef BUYRUK_ONBELLEGI_SAYAC_EN
    ,
    .isabet_sayisi_o  (isabet_sayisi_o),
    .iskalama_sayisi_o(iskalama_sayisi_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) gecen++;
    else $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
  endtask

  task automatic tik();
    @(posedge clk_i);
    #1;
  endtask

  task automatic getir_isabet(input logic [31:0] adres, input logic [31:0] beklenen);
    istek_i = 1'b1;
    adres_i = adres;
    #1 kontrol("isabet_kabul_hazir", 32'(istek_hazir_o), 32'd1);
    tik();
    istek_i = 1'b0;
    #1;
    kontrol("isabet_gecerli", 32'(buyruk_gecerli_o), 32'd1);
    kontrol("isabet_buyruk", buyruk_o, beklenen);
    kontrol("isabet_obek_istek_yok", 32'(obek_istek_o), 32'd0);
    $display("isabet adres=%h buyruk=%h", adres, buyruk_o);
    tik();
  endtask

  task automatic getir_iskalama(input logic [31:0] adres, input logic [127:0] satir,
                                input logic [31:0] beklenen, input int gecikme);
    istek_i = 1'b1;
    adres_i = adres;
    #1 kontrol("iska_kabul_hazir", 32'(istek_hazir_o), 32'd1);
    tik();
    istek_i = 1'b0;
    #1 kontrol("iska_gecersiz", 32'(buyruk_gecerli_o), 32'd0);
    tik();
    #1;
    kontrol("obek_istek", 32'(obek_istek_o), 32'd1);
    kontrol("obek_adres", obek_adres_o, adres & 32'hFFFF_FFF0);
    for (int i = 0; i < gecikme; i++) begin
      tik();
      #1 kontrol("obek_istek_tut", 32'(obek_istek_o), 32'd1);
    end
    obek_gecerli_i = 1'b1;
    obek_i         = satir;
    tik();
    obek_gecerli_i = 1'b0;
    #1;
    kontrol("yanit_gecerli", 32'(buyruk_gecerli_o), 32'd1);
    kontrol("yanit_buyruk", buyruk_o, beklenen);
    kontrol("obek_istek_dus", 32'(obek_istek_o), 32'd0);
    $display("iskalama adres=%h buyruk=%h", adres, buyruk_o);
    tik();
  endtask

  initial begin
    rst_i          = 1'b0;
    istek_i        = 1'b0;
    adres_i        = '0;
    durdur_i       = 1'b0;
    temizle_i      = 1'b0;
    obek_gecerli_i = 1'b0;
    obek_i         = '0;
    tik();
    tik();
    rst_i = 1'b1;
    #1;
    kontrol("sifir_hazir", 32'(istek_hazir_o), 32'd1);
    kontrol("sifir_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("sifir_obek_istek", 32'(obek_istek_o), 32'd0);
    kontrol("sifir_buyruk", buyruk_o, 32'd0);

    // Miss then hit within the same line.
    getir_iskalama(32'h0000_1004, SATIR_T1, 32'h1111_1111, 1);
    getir_isabet(32'h0000_1008, 32'h2222_2222);
`ifdef BUYRUK_ONBELLEGI_SAYAC_EN
    kontrol("sayac_isabet", isabet_sayisi_o, 32'd1);
    kontrol("sayac_iskalama", iskalama_sayisi_o, 32'd1);
`endif

    // Round-robin replacement in set 0.
    rst_i = 1'b0;
    tik();
    rst_i = 1'b1;
    getir_iskalama(32'h0000_1000, SATIR_A, 32'h1000_0000, 3);
    getir_iskalama(32'h0000_2000, SATIR_B, 32'h2000_0000, 0);
    getir_isabet(32'h0000_1000, 32'h1000_0000);
    getir_isabet(32'h0000_2000, 32'h2000_0000);
    getir_iskalama(32'h0000_3000, SATIR_C, 32'h3000_0000, 2);
    getir_isabet(32'h0000_2004, 32'h2000_0001);
    getir_iskalama(32'h0000_1000, SATIR_A, 32'h1000_0000, 1);

    // Back-to-back hits, one per cycle.
    for (int i = 0; i < 4; i++) begin
      istek_i = 1'b1;
      adres_i = 32'h0000_1000 + 32'(4 * i);
      #1 kontrol("ardisik_hazir", 32'(istek_hazir_o), 32'd1);
      tik();
      #1;
      kontrol("ardisik_gecerli", 32'(buyruk_gecerli_o), 32'd1);
      kontrol("ardisik_buyruk", buyruk_o, 32'h1000_0000 + 32'(i));
      $display("ardisik adres=%h buyruk=%h", 32'h0000_1000 + 32'(4 * i), buyruk_o);
    end
    istek_i = 1'b0;
    tik();

    // Stall on a hit for three cycles, then flush.
    istek_i = 1'b1;
    adres_i = 32'h0000_1004;
    tik();
    istek_i  = 1'b0;
    durdur_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      kontrol("durdur_gecerli", 32'(buyruk_gecerli_o), 32'd1);
      kontrol("durdur_buyruk", buyruk_o, 32'h1000_0001);
      kontrol("durdur_hazir", 32'(istek_hazir_o), 32'd0);
      tik();
    end
    durdur_i = 1'b0;
    #1 kontrol("durdur_bitti_hazir", 32'(istek_hazir_o), 32'd1);
    tik();
    temizle_i = 1'b1;
    tik();
    temizle_i = 1'b0;
    getir_iskalama(32'h0000_1000, SATIR_A, 32'h1000_0000, 0);

    // Flush during a refill: the word is still delivered, then the line is gone.
    istek_i = 1'b1;
    adres_i = 32'h0000_5000;
    tik();
    istek_i = 1'b0;
    tik();
    temizle_i = 1'b1;
    tik();
    temizle_i = 1'b0;
    tik();
    obek_gecerli_i = 1'b1;
    obek_i         = SATIR_D;
    tik();
    obek_gecerli_i = 1'b0;
    #1;
    kontrol("bekleyen_temizle_gecerli", 32'(buyruk_gecerli_o), 32'd1);
    kontrol("bekleyen_temizle_buyruk", buyruk_o, 32'h5000_0000);
    $display("iskalama adres=%h buyruk=%h (temizle beklemede)", 32'h0000_5000, buyruk_o);
    tik();
    getir_iskalama(32'h0000_5000, SATIR_D, 32'h5000_0000, 0);

    // Reset in the middle of a refill.
    istek_i = 1'b1;
    adres_i = 32'h0000_6004;
    tik();
    istek_i = 1'b0;
    tik();
    #1 kontrol("sifir_oncesi_obek_istek", 32'(obek_istek_o), 32'd1);
    rst_i = 1'b0;
    #1;
    kontrol("async_sifir_obek_istek", 32'(obek_istek_o), 32'd0);
    kontrol("async_sifir_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    tik();
    tik();
    rst_i          = 1'b1;
    obek_gecerli_i = 1'b1;
    obek_i         = SATIR_E;
    tik();
    obek_gecerli_i = 1'b0;
    #1 kontrol("gec_obek_yok_say", 32'(buyruk_gecerli_o), 32'd0);
    tik();
    getir_iskalama(32'h0000_6004, SATIR_E, 32'h6000_0001, 2);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/buyruk_onbellegi_kume.md
Name: buyruk_onbellegi_kume

Overview:
Parametrised N-way set-associative instruction cache, the successor to the direct-mapped fetch cache. It sits between the fetch stage and the main-memory line interface. Hits return one 32-bit instruction per cycle in a pipelined fashion. Misses issue a line-refill request, fill the victim way chosen by a per-set round-robin pointer, then forward the instruction. Adds a request/ready handshake, whole-cache invalidation, and optional hit/miss counters.

Parameters:
YOL_SAYISI, 2, number of ways; power of two, 1..8
KUME_SAYISI, 64, number of sets; power of two, >=2
OBEK_BIT, 128, line width in bits; one of 64, 128, 256
Derived: OFS=log2(OBEK_BIT/8), IDX=log2(KUME_SAYISI), ETIKET=32-IDX-OFS

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
istek_i  in  1  fetch request valid
adres_i  in  32  fetch byte address; bits [1:0] ignored (word-aligned)
istek_hazir_o  out  1  request accepted this cycle when istek_i && istek_hazir_o
durdur_i  in  1  pipeline stall
temizle_i  in  1  invalidate all lines (single-cycle pulse)
buyruk_o  out  32  instruction
buyruk_gecerli_o  out  1  buyruk_o valid
obek_istek_o  out  1  line refill request, held until served
obek_adres_o  out  32  line-aligned refill address (low OFS bits zero)
obek_gecerli_i  in  1  refill data valid (one-cycle pulse)
obek_i  in  OBEK_BIT  refill line; byte 0 at bits [7:0]

Behaviour:
- Storage: valid bit, tag, and line per (set, way) in flops; round-robin pointer per set (log2 YOL_SAYISI bits). Address split: tag [31:IDX+OFS], index [IDX+OFS-1:OFS], word [OFS-1:2].
- Reset (async, rst_i=0): state BOSTA; all valid bits and pointers cleared; temizle pending cleared. All outputs 0 except istek_hazir_o=1 once rst_i=1.
- States: BOSTA, ARA, ANABELLEK, YANIT.
- BOSTA: istek_hazir_o=!durdur_i. On accept, latch the address -> ARA.
- ARA: tag compare across all ways of the latched set.
  - Hit: buyruk_gecerli_o=1, buyruk_o = word from the hit way. Hit latency is 1 cycle after accept.
  - While a hit is held with durdur_i=0, istek_hazir_o=1. A new request accepted in the same cycle stays in ARA, giving back-to-back throughput of one per cycle. With no new request -> BOSTA.
  - Miss: buyruk_gecerli_o=0 -> ANABELLEK.
- ANABELLEK: obek_istek_o=1 and obek_adres_o are stable until obek_gecerli_i. On obek_gecerli_i:
  - write tag and line into way ptr[set], set valid, ptr[set] <= ptr+1 (wraps at YOL_SAYISI);
  - register the requested word from obek_i; go to YANIT.
  - obek_istek_o drops in the cycle after obek_gecerli_i. durdur_i is ignored in this state; the fill always completes.
- YANIT: buyruk_gecerli_o=1 with the fill word; istek_hazir_o=!durdur_i; accept -> ARA, else -> BOSTA. Miss latency is memory latency + 2 cycles from accept.
- durdur_i=1 in ARA (hit) or YANIT: state, buyruk_o, and buyruk_gecerli_o hold; no accept.
- temizle_i:
  - in BOSTA, ARA, or YANIT: all valid bits cleared at the next edge. A lookup in the same cycle uses the pre-clear contents.
  - in ANABELLEK: latched as pending and applied on leaving YANIT. The fresh fill is then invalidated too.
- Simultaneous fill and lookup cannot occur, because lookups are blocked during ANABELLEK.
- Invalid ways are not preferred over the pointer; replacement is purely round-robin.
- Reset mid-miss: obek_istek_o deasserts asynchronously. A late obek_gecerli_i after reset is ignored in BOSTA.

Optional Feature:
Macro BUYRUK_ONBELLEGI_SAYAC_EN.
- Defined: adds ports isabet_sayisi_o (out, 32) and iskalama_sayisi_o (out, 32).
  - isabet_sayisi_o increments on each ARA hit whose output is consumed: counted once, on the first cycle with durdur_i=0.
  - iskalama_sayisi_o increments on each ARA->ANABELLEK transition.
  - Both reset to 0, wrap at 2^32, and are unaffected by temizle_i.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
Defaults used (OFS=4, IDX=6).
1. Miss then hit:
   - after reset, request 0x0000_1004 -> obek_istek_o=1, obek_adres_o=0x0000_1000;
   - return obek_i=0x33333333_22222222_11111111_00000000 -> next cycle buyruk_o=0x11111111, buyruk_gecerli_o=1;
   - request 0x1008 -> 1 cycle later buyruk_o=0x22222222 with no obek_istek_o.
2. Replacement: fill 0x1000 then 0x2000 (both set 0), both hit; request 0x3000 misses and replaces way 0 -> 0x1000 now misses, 0x2000 still hits.
3. Back-to-back: requests 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles after fill -> valid on four consecutive cycles with words 0,1,2,3 of the line.
4. Stall and flush:
   - durdur_i high 3 cycles on a hit -> buyruk_o/buyruk_gecerli_o constant, istek_hazir_o=0;
   - then pulse temizle_i -> re-request 0x1000 misses.
5. Flush during miss and reset mid-miss:
   - temizle_i pulsed in ANABELLEK -> fill word still delivered, then same address misses again;
   - rst_i low during ANABELLEK -> obek_istek_o=0 immediately, later request misses.
6. With BUYRUK_ONBELLEGI_SAYAC_EN defined, scenario 1 -> isabet_sayisi_o=1, iskalama_sayisi_o=1.
